mmio_bridge: RTL

- Parametrised memory-mapped IO bridge between the CPU data path and board peripherals.
- Supports multiple LED output channels with read-back and multiple switch input channels.
- Each switch channel has a two-flop synchroniser and a debouncer.
- Selects between memory and IO read data, drives memory write data, and flags unmapped IO accesses.

---
 rtl/mmio_bridge.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mmio_bridge.sv
// Memory-mapped IO bridge: LED output channels with read-back, debounced switch inputs,
// read-data mux and sticky unmapped-access flag. Define MMIO_SW_EDGE_EN for switch edge capture.
module mmio_bridge #(
  parameter logic [31:0] IO_BASE         = 32'hFFFFFC00,
  parameter int          NUM_LED_CH      = 2,
  parameter int          NUM_SW_CH       = 2,
  parameter int          CH_WIDTH        = 16,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mem_read,
  input  logic                            mem_write,
  input  logic                            io_read,
  input  logic                            io_write,
  input  logic [31:0]                     addr_in,
  input  logic [31:0]                     m_rdata,
  input  logic [31:0]                     r_wdata,
  input  logic [NUM_SW_CH*CH_WIDTH-1:0]   sw_in,
  output logic [31:0]                     r_data,
  output logic [31:0]                     w_data,
  output logic [NUM_LED_CH*CH_WIDTH-1:0]  led_out,
  output logic                            led_ctrl,
  output logic                            switch_ctrl,
  output logic                            bad_addr
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LedW = NUM_LED_CH * CH_WIDTH;
  localparam int SwW  = NUM_SW_CH * CH_WIDTH;

  logic [LedW-1:0]           led_q, led_d;
  logic [SwW-1:0]            sync1_q, sync2_q;
  logic [SwW-1:0]            stable_q, stable_d;
  logic [NUM_SW_CH*CntW-1:0] cnt_q, cnt_d;
  logic                      bad_addr_q, bad_addr_d;

  logic [NUM_LED_CH-1:0] led_hit;
  logic [NUM_SW_CH-1:0]  sw_hit;
  logic                  mapped;

  // Loads are steered purely by io_read; mem_read carries no extra information here.
  logic unused_mem_read;
  assign unused_mem_read = mem_read;

`ifdef MMIO_SW_EDGE_EN
  logic [NUM_SW_CH-1:0] edge_hit;
  logic [SwW-1:0]       edge_q, edge_d;
`endif

  // Exact word match; any non-zero byte offset falls through as unmapped.
  always_comb begin
    led_hit = '0;
    sw_hit  = '0;
    for (int k = 0; k < NUM_LED_CH; k++) begin
      led_hit[k] = (addr_in == (IO_BASE + 32'h60 + (32'(k) << 2)));
    end
    for (int k = 0; k < NUM_SW_CH; k++) begin
      sw_hit[k] = (addr_in == (IO_BASE + 32'h70 + (32'(k) << 2)));
    end
`ifdef MMIO_SW_EDGE_EN
    edge_hit = '0;
    for (int k = 0; k < NUM_SW_CH; k++) begin
      edge_hit[k] = (addr_in == (IO_BASE + 32'h80 + (32'(k) << 2)));
    end
    mapped = (|led_hit) | (|sw_hit) | (|edge_hit);
`else
    mapped = (|led_hit) | (|sw_hit);
`endif
  end

  assign led_ctrl    = io_write & (|led_hit);
  assign switch_ctrl = io_read & (|sw_hit);
  assign w_data      = mem_write ? r_wdata : 32'h0;
  assign led_out     = led_q;
  assign bad_addr    = bad_addr_q;

  // Read data always reflects registered state, so a same-cycle write is not visible yet.
  always_comb begin
    r_data = m_rdata;
    if (io_read) begin
      r_data = 32'h0;
      for (int k = 0; k < NUM_SW_CH; k++) begin
        if (sw_hit[k]) r_data = 32'(stable_q[k*CH_WIDTH +: CH_WIDTH]);
      end
      for (int k = 0; k < NUM_LED_CH; k++) begin
        if (led_hit[k]) r_data = 32'(led_q[k*CH_WIDTH +: CH_WIDTH]);
      end
`ifdef MMIO_SW_EDGE_EN
      for (int k = 0; k < NUM_SW_CH; k++) begin
        if (edge_hit[k]) r_data = 32'(edge_q[k*CH_WIDTH +: CH_WIDTH]);
      end
`endif
    end
  end

  always_comb begin
    led_d      = led_q;
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    bad_addr_d = bad_addr_q | ((io_read | io_write) & ~mapped);
    for (int k = 0; k < NUM_LED_CH; k++) begin
      if (io_write && led_hit[k]) led_d[k*CH_WIDTH +: CH_WIDTH] = r_wdata[CH_WIDTH-1:0];
    end
    // Any return of sync2 to the accepted value restarts the stability count.
    for (int k = 0; k < NUM_SW_CH; k++) begin
      if (sync2_q[k*CH_WIDTH +: CH_WIDTH] == stable_q[k*CH_WIDTH +: CH_WIDTH]) begin
        cnt_d[k*CntW +: CntW] = '0;
      end else if (cnt_q[k*CntW +: CntW] == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[k*CH_WIDTH +: CH_WIDTH] = sync2_q[k*CH_WIDTH +: CH_WIDTH];
        cnt_d[k*CntW +: CntW]            = '0;
      end else begin
        cnt_d[k*CntW +: CntW] = cnt_q[k*CntW +: CntW] + CntW'(1);
      end
    end
  end

`ifdef MMIO_SW_EDGE_EN
  // Clear is applied before set so a coincident rise survives.
  always_comb begin
    edge_d = edge_q;
    for (int k = 0; k < NUM_SW_CH; k++) begin
      if (io_write && edge_hit[k]) begin
        edge_d[k*CH_WIDTH +: CH_WIDTH] = edge_q[k*CH_WIDTH +: CH_WIDTH] & ~r_wdata[CH_WIDTH-1:0];
      end
    end
    edge_d = edge_d | (stable_d & ~stable_q);
  end

  always_ff @(posedge clk) begin
    if (rst) edge_q <= '0;
    else     edge_q <= edge_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      bad_addr_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      sync1_q    <= sw_in;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      bad_addr_q <= bad_addr_d;
    end
  end

endmodule
